hash_stream_feeder: RTL and testbench

Upstream producer for the hash-table join stage: accepts one raw 64-bit tuple stream carrying the build relation followed by the probe relation, and computes a 32-bit hash of each key (`data[31:0]`) in a fixed 3-stage pipeline. It drives the table's build port (data, hash, valid, last) and probe port (data, hash, valid, last, serial number) under ready/valid flow control. It sits between the partition reader and the hash table and owns the build→probe phase switch.

---
 rtl/hash_stream_feeder.sv | 225 ++++++++++++++++++++++
 tb/tb_hash_stream_feeder.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_stream_feeder.sv
// hash_stream_feeder: hashes the key of each tuple in a fixed 3-stage pipeline and feeds
// the join table's build port, then its probe port, owning the build->probe switch.
// Optional macro HASH_FEEDER_FMIX_EN selects the fmix32 hash; otherwise the key passes through.
module hash_stream_feeder #(
  parameter logic [63:0] SERIAL_BASE = 64'd0,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [63:0]            s_data,
  input  logic                   s_valid,
  input  logic                   s_last,
  output logic                   s_ready,
  output logic [63:0]            out_data_BUILD,
  output logic [31:0]            out_hash_BUILD,
  output logic                   out_valid_BUILD,
  output logic                   out_last_BUILD,
  input  logic                   out_ready_BUILD,
  output logic [63:0]            out_data_PROBE,
  output logic [31:0]            out_hash_PROBE,
  output logic                   out_valid_PROBE,
  output logic                   out_last_PROBE,
  output logic [63:0]            out_serialnum,
  input  logic                   out_ready_PROBE,
  output logic [COUNT_WIDTH-1:0] build_count,
  output logic [COUNT_WIDTH-1:0] probe_count,
  output logic                   done
);

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned HASH_W   = 32;
  localparam int unsigned SERIAL_W = 64;

  typedef enum logic [1:0] {ST_BUILD, ST_DRAIN, ST_PROBE, ST_DONE} state_t;

  // Hash round 1 (or key pass-through).
  function automatic logic [HASH_W-1:0] mix1(input logic [HASH_W-1:0] k);
    logic [HASH_W-1:0] h;
`ifdef HASH_FEEDER_FMIX_EN
    h = (k ^ (k >> 16)) * 32'h85EBCA6B;
`else
    h = k;
`endif
    return h;
  endfunction

  // Hash round 2 (or pass-through).
  function automatic logic [HASH_W-1:0] mix2(input logic [HASH_W-1:0] k);
    logic [HASH_W-1:0] h;
`ifdef HASH_FEEDER_FMIX_EN
    h = (k ^ (k >> 13)) * 32'hC2B2AE35;
`else
    h = k;
`endif
    return h;
  endfunction

  // Hash round 3 (or pass-through).
  function automatic logic [HASH_W-1:0] mix3(input logic [HASH_W-1:0] k);
    logic [HASH_W-1:0] h;
`ifdef HASH_FEEDER_FMIX_EN
    h = k ^ (k >> 16);
`else
    h = k;
`endif
    return h;
  endfunction

  state_t                state_q, state_d;
  logic                  plast_q, plast_d;
  logic [SERIAL_W-1:0]   serial_q, serial_d;
  logic                  done_q, done_d;
  logic [COUNT_WIDTH-1:0] bcnt_q, bcnt_d, pcnt_q, pcnt_d;

  logic                  s1_valid_q, s1_valid_d, s1_last_q, s1_last_d, s1_phase_q, s1_phase_d;
  logic [DATA_W-1:0]     s1_data_q, s1_data_d;
  logic [HASH_W-1:0]     s1_hash_q, s1_hash_d;
  logic [SERIAL_W-1:0]   s1_serial_q, s1_serial_d;
  logic                  s2_valid_q, s2_valid_d, s2_last_q, s2_last_d, s2_phase_q, s2_phase_d;
  logic [DATA_W-1:0]     s2_data_q, s2_data_d;
  logic [HASH_W-1:0]     s2_hash_q, s2_hash_d;
  logic [SERIAL_W-1:0]   s2_serial_q, s2_serial_d;

  logic                  ob_valid_q, ob_valid_d, ob_last_q, ob_last_d;
  logic [DATA_W-1:0]     ob_data_q, ob_data_d;
  logic [HASH_W-1:0]     ob_hash_q, ob_hash_d;
  logic                  op_valid_q, op_valid_d, op_last_q, op_last_d;
  logic [DATA_W-1:0]     op_data_q, op_data_d;
  logic [HASH_W-1:0]     op_hash_q, op_hash_d;
  logic [SERIAL_W-1:0]   op_serial_q, op_serial_d;

  logic v3, rdy3, adv, open_state, accept, in_probe, hs_b, hs_p, to_build, to_probe;

  // Global advance and input handshake; s_ready never depends on s_valid.
  always_comb begin
    v3         = ob_valid_q | op_valid_q;
    rdy3       = op_valid_q ? out_ready_PROBE : out_ready_BUILD;
    adv        = ~v3 | rdy3;
    in_probe   = (state_q == ST_PROBE);
    open_state = (state_q == ST_BUILD) | (in_probe & ~plast_q);
    s_ready    = resetn & adv & open_state;
    accept     = s_valid & s_ready;
    hs_b       = ob_valid_q & out_ready_BUILD;
    hs_p       = op_valid_q & out_ready_PROBE;
    to_build   = s2_valid_q & ~s2_phase_q;
    to_probe   = s2_valid_q & s2_phase_q;
  end

  // Pipeline next-state: all stages shift together on adv, else hold.
  always_comb begin
    s1_valid_d  = s1_valid_q;  s1_last_d = s1_last_q;  s1_phase_d = s1_phase_q;
    s1_data_d   = s1_data_q;   s1_hash_d = s1_hash_q;  s1_serial_d = s1_serial_q;
    s2_valid_d  = s2_valid_q;  s2_last_d = s2_last_q;  s2_phase_d = s2_phase_q;
    s2_data_d   = s2_data_q;   s2_hash_d = s2_hash_q;  s2_serial_d = s2_serial_q;
    ob_valid_d  = ob_valid_q;  ob_last_d = ob_last_q;  ob_data_d = ob_data_q;  ob_hash_d = ob_hash_q;
    op_valid_d  = op_valid_q;  op_last_d = op_last_q;  op_data_d = op_data_q;  op_hash_d = op_hash_q;
    op_serial_d = op_serial_q;
    if (adv) begin
      s1_valid_d  = accept;
      s1_last_d   = s_last;
      s1_phase_d  = in_probe;
      s1_data_d   = s_data;
      s1_hash_d   = mix1(s_data[HASH_W-1:0]);
      s1_serial_d = serial_q;
      s2_valid_d  = s1_valid_q;
      s2_last_d   = s1_last_q;
      s2_phase_d  = s1_phase_q;
      s2_data_d   = s1_data_q;
      s2_hash_d   = mix2(s1_hash_q);
      s2_serial_d = s1_serial_q;
      ob_valid_d  = to_build;
      op_valid_d  = to_probe;
      ob_last_d   = 1'b0;
      op_last_d   = 1'b0;
      if (to_build) begin
        ob_data_d = s2_data_q;
        ob_hash_d = mix3(s2_hash_q);
        ob_last_d = s2_last_q;
      end
      if (to_probe) begin
        op_data_d   = s2_data_q;
        op_hash_d   = mix3(s2_hash_q);
        op_last_d   = s2_last_q;
        op_serial_d = s2_serial_q;
      end
    end
  end

  // Phase FSM, probe serial allocation and done flag.
  always_comb begin
    state_d  = state_q;
    plast_d  = plast_q;
    serial_d = serial_q;
    case (state_q)
      ST_BUILD: if (accept & s_last) state_d = ST_DRAIN;
      ST_DRAIN: if (hs_b & ob_last_q) state_d = ST_PROBE;
      ST_PROBE: begin
        if (accept) serial_d = serial_q + SERIAL_W'(1);
        if (accept & s_last) plast_d = 1'b1;
        if (hs_p & op_last_q) begin
          state_d = ST_DONE;
          plast_d = 1'b0;
        end
      end
      ST_DONE:  state_d = ST_DONE;
      default:  state_d = ST_BUILD;
    endcase
    done_d = (state_d == ST_DONE);
  end

  // Saturating per-port handshake counters.
  always_comb begin
    bcnt_d = bcnt_q;
    pcnt_d = pcnt_q;
    if (hs_b && (bcnt_q != '1)) bcnt_d = bcnt_q + COUNT_WIDTH'(1);
    if (hs_p && (pcnt_q != '1)) pcnt_d = pcnt_q + COUNT_WIDTH'(1);
  end

  // State registers; reset discards in-flight tuples.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_BUILD;
      plast_q     <= 1'b0;
      serial_q    <= SERIAL_BASE;
      done_q      <= 1'b0;
      bcnt_q      <= '0;
      pcnt_q      <= '0;
      s1_valid_q  <= 1'b0; s1_last_q <= 1'b0; s1_phase_q <= 1'b0;
      s1_data_q   <= '0;   s1_hash_q <= '0;   s1_serial_q <= '0;
      s2_valid_q  <= 1'b0; s2_last_q <= 1'b0; s2_phase_q <= 1'b0;
      s2_data_q   <= '0;   s2_hash_q <= '0;   s2_serial_q <= '0;
      ob_valid_q  <= 1'b0; ob_last_q <= 1'b0; ob_data_q <= '0; ob_hash_q <= '0;
      op_valid_q  <= 1'b0; op_last_q <= 1'b0; op_data_q <= '0; op_hash_q <= '0;
      op_serial_q <= '0;
    end else begin
      state_q     <= state_d;
      plast_q     <= plast_d;
      serial_q    <= serial_d;
      done_q      <= done_d;
      bcnt_q      <= bcnt_d;
      pcnt_q      <= pcnt_d;
      s1_valid_q  <= s1_valid_d; s1_last_q <= s1_last_d; s1_phase_q <= s1_phase_d;
      s1_data_q   <= s1_data_d;  s1_hash_q <= s1_hash_d; s1_serial_q <= s1_serial_d;
      s2_valid_q  <= s2_valid_d; s2_last_q <= s2_last_d; s2_phase_q <= s2_phase_d;
      s2_data_q   <= s2_data_d;  s2_hash_q <= s2_hash_d; s2_serial_q <= s2_serial_d;
      ob_valid_q  <= ob_valid_d; ob_last_q <= ob_last_d; ob_data_q <= ob_data_d; ob_hash_q <= ob_hash_d;
      op_valid_q  <= op_valid_d; op_last_q <= op_last_d; op_data_q <= op_data_d; op_hash_q <= op_hash_d;
      op_serial_q <= op_serial_d;
    end
  end

  assign out_data_BUILD  = ob_data_q;
  assign out_hash_BUILD  = ob_hash_q;
  assign out_valid_BUILD = ob_valid_q;
  assign out_last_BUILD  = ob_last_q;
  assign out_data_PROBE  = op_data_q;
  assign out_hash_PROBE  = op_hash_q;
  assign out_valid_PROBE = op_valid_q;
  assign out_last_PROBE  = op_last_q;
  assign out_serialnum   = op_serial_q;
  assign build_count     = bcnt_q;
  assign probe_count     = pcnt_q;
  assign done            = done_q;

endmodule

// File: tb/tb_hash_stream_feeder.sv
// Directed bench for hash_stream_feeder: cycle table for build/drain/probe, plus
// sequences for probe stall, reset mid-probe and a randomly stalled 16-tuple build.
module tb_hash_stream_feeder;

  logic        clk = 1'b0;
  logic        resetn;
  logic [63:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [63:0] out_data_BUILD, out_data_PROBE, out_serialnum;
  logic [31:0] out_hash_BUILD, out_hash_PROBE;
  logic        out_valid_BUILD, out_last_BUILD, out_ready_BUILD;
  logic        out_valid_PROBE, out_last_PROBE, out_ready_PROBE;
  logic [31:0] build_count, probe_count;
  logic        done;

  int n_vec  = 0;
  int n_miss = 0;

  hash_stream_feeder #(.SERIAL_BASE(64'd0), .COUNT_WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .out_data_BUILD(out_data_BUILD), .out_hash_BUILD(out_hash_BUILD),
    .out_valid_BUILD(out_valid_BUILD), .out_last_BUILD(out_last_BUILD),
    .out_ready_BUILD(out_ready_BUILD),
    .out_data_PROBE(out_data_PROBE), .out_hash_PROBE(out_hash_PROBE),
    .out_valid_PROBE(out_valid_PROBE), .out_last_PROBE(out_last_PROBE),
    .out_serialnum(out_serialnum), .out_ready_PROBE(out_ready_PROBE),
    .build_count(build_count), .probe_count(probe_count), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

`ifdef HASH_FEEDER_FMIX_EN
  localparam logic [31:0] KEY1_HASH = 32'h514E28B7;
`else
  localparam logic [31:0] KEY1_HASH = 32'h00000001;
`endif

  // Reference hash written directly from the algorithm description.
  function automatic logic [31:0] hf(input logic [31:0] k);
    logic [31:0] h;
`ifdef HASH_FEEDER_FMIX_EN
    h = k ^ (k >> 16);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    h = h * 32'hC2B2AE35;
    h = h ^ (h >> 16);
`else
    h = k;
`endif
    return h;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic sv; logic sl; logic [63:0] sd; logic rb;
    logic e_sr;
    logic e_vb; logic e_lb; logic [63:0] e_db;
    logic e_vp; logic e_lp; logic [63:0] e_dp; logic [63:0] e_ser;
    logic e_dn; logic [31:0] e_bc; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic sl, input logic [63:0] sd, input logic rb,
                              input logic e_sr, input logic e_vb, input logic e_lb, input logic [63:0] e_db,
                              input logic e_vp, input logic e_lp, input logic [63:0] e_dp,
                              input logic [63:0] e_ser, input logic e_dn,
                              input logic [31:0] e_bc, input logic [31:0] e_pc);
    vec_t v;
    v.sv = sv; v.sl = sl; v.sd = sd; v.rb = rb; v.e_sr = e_sr;
    v.e_vb = e_vb; v.e_lb = e_lb; v.e_db = e_db;
    v.e_vp = e_vp; v.e_lp = e_lp; v.e_dp = e_dp; v.e_ser = e_ser;
    v.e_dn = e_dn; v.e_bc = e_bc; v.e_pc = e_pc;
    return v;
  endfunction

  typedef struct { logic [63:0] d; logic [31:0] h; logic [63:0] s; logic l; } obs_t;
  obs_t gotp[$];
  obs_t gotb[$];
  bit   rand_run;

  // Record every output handshake (ready and valid stable at the falling edge).
  always @(negedge clk) begin
    obs_t o;
    if (resetn) begin
      if (out_valid_PROBE && out_ready_PROBE) begin
        o.d = out_data_PROBE; o.h = out_hash_PROBE; o.s = out_serialnum; o.l = out_last_PROBE;
        gotp.push_back(o);
      end
      if (out_valid_BUILD && out_ready_BUILD) begin
        o.d = out_data_BUILD; o.h = out_hash_BUILD; o.s = 64'd0; o.l = out_last_BUILD;
        gotb.push_back(o);
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    out_ready_BUILD = 1'b1; out_ready_PROBE = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
  endtask

  // Present one tuple until accepted; returns at posedge+1 after acceptance.
  task automatic send(input logic [63:0] d, input logic l);
    logic acc;
    acc = 1'b0;
    s_valid = 1'b1; s_data = d; s_last = l;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    chk($sformatf("send_accept %h", d), 64'(acc), 64'd1);
  endtask

  task automatic wait_done();
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (done) break;
    end
    chk("wait_done", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] CB0 = 64'hCAFE_0000_0000_0000;
  localparam logic [63:0] CB1 = 64'hCAFE_0001_0000_0001;
  localparam logic [63:0] P0  = 64'h1111_2222_0000_0100;
  localparam logic [63:0] P1  = 64'h3333_4444_8000_0001;
  localparam logic [63:0] P2  = 64'h5555_6666_FFFF_FFFF;

  vec_t        tv[14];
  logic [63:0] qd[4];

  initial begin
    //            sv sl sd   rb  sr  vb lb db   vp lp dp  ser   dn bc pc
    tv[0]  = mk(1, 0, CB0, 1,  1,  0, 0, 0,   0, 0, 0,  0,    0, 0, 0);
    tv[1]  = mk(1, 1, CB1, 1,  1,  0, 0, 0,   0, 0, 0,  0,    0, 0, 0);
    tv[2]  = mk(1, 0, P0,  1,  0,  0, 0, 0,   0, 0, 0,  0,    0, 0, 0);
    tv[3]  = mk(1, 0, P0,  1,  0,  1, 0, CB0, 0, 0, 0,  0,    0, 0, 0);
    tv[4]  = mk(1, 0, P0,  0,  0,  1, 1, CB1, 0, 0, 0,  0,    0, 1, 0);
    tv[5]  = mk(1, 0, P0,  0,  0,  1, 1, CB1, 0, 0, 0,  0,    0, 1, 0);
    tv[6]  = mk(1, 0, P0,  1,  0,  1, 1, CB1, 0, 0, 0,  0,    0, 1, 0);
    tv[7]  = mk(1, 0, P0,  1,  1,  0, 0, 0,   0, 0, 0,  0,    0, 2, 0);
    tv[8]  = mk(1, 0, P1,  1,  1,  0, 0, 0,   0, 0, 0,  0,    0, 2, 0);
    tv[9]  = mk(1, 1, P2,  1,  1,  0, 0, 0,   0, 0, 0,  0,    0, 2, 0);
    tv[10] = mk(0, 0, 0,   1,  0,  0, 0, 0,   1, 0, P0, 0,    0, 2, 0);
    tv[11] = mk(0, 0, 0,   1,  0,  0, 0, 0,   1, 0, P1, 1,    0, 2, 1);
    tv[12] = mk(0, 0, 0,   1,  0,  0, 0, 0,   1, 1, P2, 2,    0, 2, 2);
    tv[13] = mk(0, 0, 0,   1,  0,  0, 0, 0,   0, 0, 0,  0,    1, 2, 3);

    // Reset values while reset is held
    resetn = 1'b0;
    s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    out_ready_BUILD = 1'b1; out_ready_PROBE = 1'b1;
    rand_run = 1'b0;
    @(negedge clk);
    chk("rst s_ready", 64'(s_ready), 64'd0);
    chk("rst valid_b", 64'(out_valid_BUILD), 64'd0);
    chk("rst valid_p", 64'(out_valid_PROBE), 64'd0);
    chk("rst last_b", 64'(out_last_BUILD), 64'd0);
    chk("rst last_p", 64'(out_last_PROBE), 64'd0);
    chk("rst data_b", out_data_BUILD, 64'd0);
    chk("rst data_p", out_data_PROBE, 64'd0);
    chk("rst hash_b", 64'(out_hash_BUILD), 64'd0);
    chk("rst hash_p", 64'(out_hash_PROBE), 64'd0);
    chk("rst serial", out_serialnum, 64'd0);
    chk("rst build_count", 64'(build_count), 64'd0);
    chk("rst probe_count", 64'(probe_count), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Cycle table: build 2, stalled drain, probe 3, done
    for (int i = 0; i < 14; i++) begin
      s_valid = tv[i].sv; s_last = tv[i].sl; s_data = tv[i].sd;
      out_ready_BUILD = tv[i].rb; out_ready_PROBE = 1'b1;
      @(negedge clk);
      chk($sformatf("v%0d s_ready", i), 64'(s_ready), 64'(tv[i].e_sr));
      chk($sformatf("v%0d valid_b", i), 64'(out_valid_BUILD), 64'(tv[i].e_vb));
      if (tv[i].e_vb) begin
        chk($sformatf("v%0d data_b", i), out_data_BUILD, tv[i].e_db);
        chk($sformatf("v%0d hash_b", i), 64'(out_hash_BUILD), 64'(hf(tv[i].e_db[31:0])));
        chk($sformatf("v%0d last_b", i), 64'(out_last_BUILD), 64'(tv[i].e_lb));
      end
      if (i == 4) chk("key1 hash constant", 64'(out_hash_BUILD), 64'(KEY1_HASH));
      chk($sformatf("v%0d valid_p", i), 64'(out_valid_PROBE), 64'(tv[i].e_vp));
      if (tv[i].e_vp) begin
        chk($sformatf("v%0d data_p", i), out_data_PROBE, tv[i].e_dp);
        chk($sformatf("v%0d hash_p", i), 64'(out_hash_PROBE), 64'(hf(tv[i].e_dp[31:0])));
        chk($sformatf("v%0d serial", i), out_serialnum, tv[i].e_ser);
        chk($sformatf("v%0d last_p", i), 64'(out_last_PROBE), 64'(tv[i].e_lp));
      end
      chk($sformatf("v%0d done", i), 64'(done), 64'(tv[i].e_dn));
      chk($sformatf("v%0d build_count", i), 64'(build_count), 64'(tv[i].e_bc));
      chk($sformatf("v%0d probe_count", i), 64'(probe_count), 64'(tv[i].e_pc));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk("build data held", out_data_BUILD, CB1);
    chk("done s_ready", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;

    // Probe stall with full pipeline
    do_reset();
    qd[0] = 64'hA000_0000_0000_0010; qd[1] = 64'hA000_0001_1234_5678;
    qd[2] = 64'hA000_0002_0000_FFFF; qd[3] = 64'hA000_0003_DEAD_BEEF;
    send(64'hB0B0_0000_0000_0007, 1'b1);
    gotp.delete();
    out_ready_PROBE = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(qd[i], 1'(i == 3));
      end
      begin
        for (int t = 0; t < 50; t++) begin
          @(negedge clk);
          if (out_valid_PROBE) break;
        end
        for (int k = 0; k < 5; k++) begin
          chk($sformatf("stall%0d s_ready", k), 64'(s_ready), 64'd0);
          chk($sformatf("stall%0d valid_p", k), 64'(out_valid_PROBE), 64'd1);
          chk($sformatf("stall%0d data_p", k), out_data_PROBE, qd[0]);
          chk($sformatf("stall%0d hash_p", k), 64'(out_hash_PROBE), 64'(hf(qd[0][31:0])));
          chk($sformatf("stall%0d serial", k), out_serialnum, 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready_PROBE = 1'b1;
      end
    join
    wait_done();
    chk("stall probe n", 64'(gotp.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < gotp.size()) begin
        chk($sformatf("stall out%0d data", i), gotp[i].d, qd[i]);
        chk($sformatf("stall out%0d hash", i), 64'(gotp[i].h), 64'(hf(qd[i][31:0])));
        chk($sformatf("stall out%0d serial", i), gotp[i].s, 64'(i));
        chk($sformatf("stall out%0d last", i), 64'(gotp[i].l), 64'(i == 3));
      end
    end
    chk("stall probe_count", 64'(probe_count), 64'd4);
    chk("stall build_count", 64'(build_count), 64'd1);

    // Reset with probe tuples in flight
    do_reset();
    send(64'hC0C0_0000_0000_0042, 1'b1);
    out_ready_PROBE = 1'b0;
    send(64'hD000_0000_0000_0001, 1'b0);
    send(64'hD000_0000_0000_0002, 1'b0);
    @(posedge clk);
    #1;
    chk("inflight valid_p", 64'(out_valid_PROBE), 64'd1);
    resetn = 1'b0;
    #1;
    chk("midrst valid_p", 64'(out_valid_PROBE), 64'd0);
    chk("midrst data_p", out_data_PROBE, 64'd0);
    chk("midrst serial", out_serialnum, 64'd0);
    chk("midrst build_count", 64'(build_count), 64'd0);
    chk("midrst s_ready", 64'(s_ready), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    out_ready_PROBE = 1'b1;
    gotp.delete();
    send(64'hC0C0_0000_0000_0043, 1'b1);
    send(64'hE000_0000_0000_0099, 1'b1);
    wait_done();
    chk("postrst probe n", 64'(gotp.size()), 64'd1);
    if (gotp.size() > 0) begin
      chk("postrst serial", gotp[0].s, 64'd0);
      chk("postrst data", gotp[0].d, 64'hE000_0000_0000_0099);
    end
    chk("postrst probe_count", 64'(probe_count), 64'd1);
    chk("postrst build_count", 64'(build_count), 64'd1);

    // 16 back-to-back build tuples with random build-port ready
    do_reset();
    gotb.delete();
    rand_run = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++)
          send({32'(i) + 32'h0000_0100, 32'h9E37_79B9 * 32'(i + 1)}, 1'(i == 15));
        for (int t = 0; t < 300; t++) begin
          @(negedge clk);
          if (gotb.size() >= 16) break;
        end
        rand_run = 1'b0;
      end
      begin
        while (rand_run) begin
          @(posedge clk);
          #1 out_ready_BUILD = 1'($urandom_range(0, 1));
        end
        out_ready_BUILD = 1'b1;
      end
    join
    @(negedge clk);
    chk("rand build n", 64'(gotb.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < gotb.size()) begin
        logic [63:0] ed;
        ed = {32'(i) + 32'h0000_0100, 32'h9E37_79B9 * 32'(i + 1)};
        chk($sformatf("rand out%0d data", i), gotb[i].d, ed);
        chk($sformatf("rand out%0d hash", i), 64'(gotb[i].h), 64'(hf(ed[31:0])));
        chk($sformatf("rand out%0d last", i), 64'(gotb[i].l), 64'(i == 15));
      end
    end
    chk("rand build_count", 64'(build_count), 64'd16);
    chk("rand probe_count", 64'(probe_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
